// File: rtl/pc_unit.sv
// Program-counter unit for the pipelined LEGv8 fetch stage: reset vector,
// stall hold, branch redirect with a one-deep buffer while stalled, and misalign flag.
module pc_unit #(
  parameter int unsigned              ADDR_W      = 64,
  parameter logic [ADDR_W-1:0]        RESET_VEC   = '0,
  parameter int unsigned              INSTR_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_seq_o,
  output logic              pc_valid_o,
  output logic              redirect_taken_o,
  output logic              misalign_o,
  output logic              pending_o
);

  localparam logic [ADDR_W-1:0] INCR     = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(INSTR_BYTES - 1);

  typedef enum logic [2:0] {
    ACT_INIT,      // first cycle out of reset: only raise valid
    ACT_BUFFER,    // stalled with a live redirect: capture it
    ACT_HOLD,      // stalled, nothing new
    ACT_REDIRECT,  // live redirect applied
    ACT_PENDING,   // buffered redirect applied
    ACT_SEQ        // sequential fetch
  } act_e;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_valid;
  logic              r_pending;
  logic              r_taken;
  logic              r_misalign;

  act_e              w_act;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pend_addr_nxt;
  logic              w_pending_nxt;
  logic              w_taken_nxt;
  logic              w_misalign_nxt;

  always_comb begin
    if (!r_valid)                   w_act = ACT_INIT;
    else if (stall_i && redirect_i) w_act = ACT_BUFFER;
    else if (stall_i)               w_act = ACT_HOLD;
    else if (redirect_i)            w_act = ACT_REDIRECT;
    else if (r_pending)             w_act = ACT_PENDING;
    else                            w_act = ACT_SEQ;
  end

  // A live redirect beats a buffered one, so the buffer is only the target otherwise.
  assign w_target = (w_act == ACT_REDIRECT) ? redirect_addr_i : r_pend_addr;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_pc_nxt        = r_pc;
    w_pend_addr_nxt = r_pend_addr;
    w_pending_nxt   = r_pending;
    w_taken_nxt     = 1'b0;
    w_misalign_nxt  = 1'b0;
    unique case (w_act)
      ACT_INIT, ACT_HOLD: ;
      ACT_BUFFER: begin
        w_pending_nxt   = 1'b1;
        w_pend_addr_nxt = redirect_addr_i;
      end
      ACT_REDIRECT, ACT_PENDING: begin
        w_pc_nxt        = w_target & ~OFF_MASK;
        w_pending_nxt   = 1'b0;
        w_pend_addr_nxt = '0;
        w_taken_nxt     = 1'b1;
        w_misalign_nxt  = |(w_target & OFF_MASK);
      end
      ACT_SEQ: w_pc_nxt = pc_seq_o;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!rst_n) begin
      r_pc        <= RESET_VEC;
      r_pend_addr <= '0;
      r_valid     <= 1'b0;
      r_pending   <= 1'b0;
      r_taken     <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_valid     <= 1'b1;
      r_pending   <= w_pending_nxt;
      r_taken     <= w_taken_nxt;
      r_misalign  <= w_misalign_nxt;
    end
  end

  assign pc_o             = r_pc;
  assign pc_seq_o         = r_pc + INCR;
  assign pc_valid_o       = r_valid;
  assign redirect_taken_o = r_taken;
  assign misalign_o       = r_misalign;
  assign pending_o        = r_pending;

endmodule
